ysyx_22041412_rf_sched: RTL

Register-file write scheduler and scoreboard for the NPC integer register file (32 × 64-bit, 2 read / 1 write, x0 hard-wired to zero).

- **Hazard tracking:** tracks pending destination registers and holds issue on RAW and WAW hazards.
- **Write-port arbitration:** shares the single write port between the fixed-latency pipeline writeback (S) and the variable-latency unit writeback (L, mul/div/load).
- **Placement:** between the issue stage and the register file; drives the register file's Wen/Rw/BusW directly.

---
 rtl/ysyx_22041412_pkg.sv | 18 +
 rtl/ysyx_22041412_scoreboard.sv | 57 +++++
 rtl/ysyx_22041412_rf_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22041412_pkg.sv
// Shared constants and types for the NPC register-file write scheduler.
//   REG_W    : register index width
//   NREG     : number of architectural integer registers
//   XLEN     : default data width
//   wb_src_e : which writeback source owns the register-file write port
package ysyx_22041412_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned NREG  = 32;
    localparam int unsigned XLEN  = 64;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_S    = 2'd1,
        WB_L    = 2'd2
    } wb_src_e;

endpackage

// File: rtl/ysyx_22041412_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, x0 never busy.
// Ports:
//   clk, rst                  clock, async active-high reset
//   i_set_en / i_set_rd       mark a destination pending (accepted issue)
//   i_clr_en / i_clr_rd       retire a destination (register-file write)
//   i_rs1*, i_rs2*, i_rd*     operands of the instruction presented at issue
//   o_busy                    registered busy vector
//   o_hazard                  RAW/WAW hazard against the registered busy vector
//   o_clr_was_busy            busy state of the register being retired
module ysyx_22041412_scoreboard
    import ysyx_22041412_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_set_en,
    input  logic [REG_W-1:0] i_set_rd,
    input  logic             i_clr_en,
    input  logic [REG_W-1:0] i_clr_rd,
    input  logic [REG_W-1:0] i_rs1,
    input  logic             i_rs1_en,
    input  logic [REG_W-1:0] i_rs2,
    input  logic             i_rs2_en,
    input  logic [REG_W-1:0] i_rd,
    input  logic             i_rd_en,
    output logic [NREG-1:0]  o_busy,
    output logic             o_hazard,
    output logic             o_clr_was_busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_busy_nxt;

    // Set and clear never target the same register (issue stalls while busy).
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en) w_set_mask[i_set_rd] = 1'b1;
        if (i_clr_en) w_clr_mask[i_clr_rd] = 1'b1;
        w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    // Hazard looks only at registered state; no same-cycle clear forwarding.
    assign o_hazard       = (i_rs1_en & r_busy[i_rs1])
                          | (i_rs2_en & r_busy[i_rs2])
                          | (i_rd_en  & r_busy[i_rd]);
    assign o_clr_was_busy = r_busy[i_clr_rd];
    assign o_busy         = r_busy;

endmodule

// File: rtl/ysyx_22041412_rf_sched.sv
// Register-file write scheduler: issue hazard gating, long-op accounting,
// S/L write-port arbitration (S wins), L starvation throttle, sticky error.
// Ports:
//   clk, rst                     clock, async active-high reset
//   iss_*                        issue-stage instruction and handshake
//   s_valid/s_rd/s_data          fixed-latency writeback (never stalled)
//   l_valid/l_ready/l_rd/l_data  variable-latency writeback handshake
//   rf_wen/rf_rw/rf_busw         register-file write port (combinational)
//   sb_busy                      scoreboard debug view
//   sb_err                       sticky protocol error
module ysyx_22041412_rf_sched
    import ysyx_22041412_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned LONG_MAX   = 4,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [REG_W-1:0] iss_rs1,
    input  logic [REG_W-1:0] iss_rs2,
    input  logic             iss_rs1_en,
    input  logic             iss_rs2_en,
    input  logic [REG_W-1:0] iss_rd,
    input  logic             iss_rd_en,
    input  logic             iss_long,
    input  logic             s_valid,
    input  logic [REG_W-1:0] s_rd,
    input  logic [XLEN-1:0]  s_data,
    input  logic             l_valid,
    output logic             l_ready,
    input  logic [REG_W-1:0] l_rd,
    input  logic [XLEN-1:0]  l_data,
    output logic             rf_wen,
    output logic [REG_W-1:0] rf_rw,
    output logic [XLEN-1:0]  rf_busw,
    output logic [NREG-1:0]  sb_busy,
    output logic             sb_err
);

    localparam int unsigned CNT_W    = $clog2(LONG_MAX + 1);
    localparam int unsigned STARVE_W = 8;

    logic [CNT_W-1:0]    r_long_cnt;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_err;

    wb_src_e             w_src;
    logic [REG_W-1:0]    w_sel_rd;
    logic [XLEN-1:0]     w_sel_data;
    logic                w_hazard;
    logic                w_clr_was_busy;
    logic                w_long_full;
    logic                w_throttle;
    logic                w_iss_fire;
    logic                w_l_fire;
    logic                w_cnt_inc;
    logic                w_cnt_dec;
    logic                w_err_set;

    assign w_long_full = (r_long_cnt == CNT_W'(LONG_MAX));
    assign w_throttle  = (r_starve_cnt == STARVE_W'(STARVE_LIM));

    // Combinational handshakes, forced low while reset is held.
    assign iss_ready  = !rst & !w_hazard & !(iss_long & w_long_full) & !(w_throttle & !iss_long);
    assign l_ready    = !rst & !s_valid;
    assign w_iss_fire = iss_valid & iss_ready;
    assign w_l_fire   = l_valid & l_ready;

    // Write-port source select: S has absolute priority over L.
    always_comb begin
        w_src      = WB_NONE;
        w_sel_rd   = '0;
        w_sel_data = '0;
        if (s_valid) begin
            w_src      = WB_S;
            w_sel_rd   = s_rd;
            w_sel_data = s_data;
        end else if (l_valid) begin
            w_src      = WB_L;
            w_sel_rd   = l_rd;
            w_sel_data = l_data;
        end
    end

    assign rf_wen  = !rst & (w_src != WB_NONE) & (w_sel_rd != '0);
    assign rf_rw   = w_sel_rd;
    assign rf_busw = w_sel_data;

    ysyx_22041412_scoreboard u_sb (
        .clk            (clk),
        .rst            (rst),
        .i_set_en       (w_iss_fire & iss_rd_en & (iss_rd != '0)),
        .i_set_rd       (iss_rd),
        .i_clr_en       (rf_wen),
        .i_clr_rd       (w_sel_rd),
        .i_rs1          (iss_rs1),
        .i_rs1_en       (iss_rs1_en),
        .i_rs2          (iss_rs2),
        .i_rs2_en       (iss_rs2_en),
        .i_rd           (iss_rd),
        .i_rd_en        (iss_rd_en),
        .o_busy         (sb_busy),
        .o_hazard       (w_hazard),
        .o_clr_was_busy (w_clr_was_busy)
    );

    // An L handshake with nothing outstanding is an error and does not underflow.
    assign w_cnt_inc = w_iss_fire & iss_long;
    assign w_cnt_dec = w_l_fire & (r_long_cnt != '0);
    assign w_err_set = (rf_wen & !w_clr_was_busy) | (w_l_fire & (r_long_cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_long_cnt <= '0;
        end else if (w_cnt_inc & !w_cnt_dec) begin
            r_long_cnt <= r_long_cnt + CNT_W'(1);
        end else if (w_cnt_dec & !w_cnt_inc) begin
            r_long_cnt <= r_long_cnt - CNT_W'(1);
        end
    end

    // Counts cycles L waits behind S; saturates at the throttle point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!l_valid | w_l_fire) begin
            r_starve_cnt <= '0;
        end else if (!w_throttle) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_err <= 1'b0;
        else if (w_err_set) r_err <= 1'b1;
    end

    assign sb_err = r_err;

endmodule
